// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding, default bus widths and
// the wait-counter width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    // Counter must hold WAIT_CYCLES itself; never narrower than one bit.
    function automatic int apb_cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// MEM_DEPTH x DATA_W register array with async clear, one write port and a
// registered read port; addresses beyond the depth alias modulo MEM_DEPTH.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_W    = APB_ADDR_W,
    parameter int DATA_W    = APB_DATA_W,
    parameter int MEM_DEPTH = 200
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rclr_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W-1:0] addr);
        return IDX_W'(32'(addr) % 32'(MEM_DEPTH));
    endfunction

    // Storage array: cleared on reset, written on commit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[to_index(waddr_i)] <= wdata_i;
        end
    end

    // Read register; rclr_i forces an error read to return zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rclr_i ? '0 : mem_q[to_index(raddr_i)];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with WAIT_CYCLES wait states in front of a register array.
// Define APB_SLVERR_EN to flag addresses >= MEM_DEPTH with PSLVERR_o.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int MEM_DEPTH   = 200,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic [ADDR_W-1:0] PADDR_i,
    input  logic [DATA_W-1:0] PWDATA_i,
    input  logic              PSEL_i,
    input  logic              PENABLE_i,
    input  logic              PWRITE_i,
    output logic              PREADY_o,
    output logic [DATA_W-1:0] PREAD_o,
    output logic              PSLVERR_o
);

    localparam int                CNT_W    = apb_cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              pready_q;
    logic              commit_s;
    logic              err_s;
    logic              rd_en_s;
    logic              we_s;
    logic [ADDR_W-1:0] eff_addr_s;

    // Next-state, counter and request capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSEL_i && !PENABLE_i) begin
                    addr_d  = PADDR_i;
                    wdata_d = PWDATA_i;
                    write_d = PWRITE_i;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_READY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!PSEL_i) begin
                    state_d = ST_IDLE;
                end else if (PENABLE_i) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_READY;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_READY: begin
                if (!PSEL_i) begin
                    state_d = ST_IDLE;
                end else if (PENABLE_i) begin
                    commit_s = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // In IDLE the live bus address is the one about to be captured.
    assign eff_addr_s = (state_q == ST_IDLE) ? PADDR_i : addr_q;

`ifdef APB_SLVERR_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    // Range decode on the address of the transfer in flight.
    always_comb begin
        err_s = ({1'b0, eff_addr_s} >= DEPTH_L);
    end
`else
    // Out-of-range addresses alias inside the array instead of erroring.
    always_comb begin
        err_s = 1'b0;
    end
`endif

    assign rd_en_s = (state_d == ST_READY) && (state_q != ST_READY) && !write_d;
    assign we_s    = commit_s && write_q && !err_s;

    // FSM and captured-request registers.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            pready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            pready_q <= (state_d == ST_READY);
        end
    end

`ifdef APB_SLVERR_EN
    logic pslverr_q;

    // Error response is valid only alongside PREADY_o.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= (state_d == ST_READY) && err_s;
        end
    end

    assign PSLVERR_o = pslverr_q;
`else
    assign PSLVERR_o = 1'b0;
`endif

    apb_slave_regfile #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_regfile (
        .clk_i   (PCLK),
        .rst_ni  (PRESET_n),
        .we_i    (we_s),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .re_i    (rd_en_s),
        .rclr_i  (err_s),
        .raddr_i (eff_addr_s),
        .rdata_o (PREAD_o)
    );

    assign PREADY_o = pready_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: one instance with two wait states, one zero-wait,
// checked against a flat array model of the memory.
module tb_apb_slave_mem;

    localparam int DEPTH = 200;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][7:0] paddr, pwdata, prdata;
    logic [1:0]      psel, pen, pwr, prdy, perr;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_mem [2][DEPTH];
    logic [7:0] last_rd [2];

    always #5 clk = ~clk;

    apb_slave_mem #(.WAIT_CYCLES(2)) u_dut_w2 (
        .PCLK(clk), .PRESET_n(rst_n), .PADDR_i(paddr[0]), .PWDATA_i(pwdata[0]),
        .PSEL_i(psel[0]), .PENABLE_i(pen[0]), .PWRITE_i(pwr[0]),
        .PREADY_o(prdy[0]), .PREAD_o(prdata[0]), .PSLVERR_o(perr[0])
    );

    apb_slave_mem #(.WAIT_CYCLES(0)) u_dut_w0 (
        .PCLK(clk), .PRESET_n(rst_n), .PADDR_i(paddr[1]), .PWDATA_i(pwdata[1]),
        .PSEL_i(psel[1]), .PENABLE_i(pen[1]), .PWRITE_i(pwr[1]),
        .PREADY_o(prdy[1]), .PREAD_o(prdata[1]), .PSLVERR_o(perr[1])
    );

    function automatic int wait_of(input bit d);
        return d ? 0 : 2;
    endfunction

    function automatic bit in_err(input logic [7:0] a);
`ifdef APB_SLVERR_EN
        return a >= 8'd200;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] model_read(input bit d, input logic [7:0] a);
        if (in_err(a)) return 8'h00;
        return ref_mem[d][a % 8'd200];
    endfunction

    // mode 0 = complete, 1 = drop PSEL during wait, 2 = drop PSEL in READY
    function automatic void model_apply(input bit d, input bit wr, input logic [7:0] a,
                                        input logic [7:0] wd, input int mode);
        if (mode != 1 && !wr) last_rd[d] = model_read(d, a);
        if (mode == 0 && wr && !in_err(a)) ref_mem[d][a % 8'd200] = wd;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = 8'h00;
            for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = 8'h00;
        end
    endfunction

    // Drives one transfer starting at a negedge; returns what was observed.
    task automatic xfer(input bit d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input int mode, input int abort_at,
                        output logic [7:0] rd, output logic err_rdy, output int waits,
                        output logic err_wait, output logic rdy_after, output logic err_after,
                        output bit tmo);
        int guard;
        tmo = 1'b0; waits = 0; err_wait = 1'b0; rd = 8'h00; err_rdy = 1'b0; guard = 0;
        psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(negedge clk);
        pen[d] = 1'b1;
        paddr[d] = 8'($urandom);
        pwdata[d] = 8'($urandom);
        while (prdy[d] !== 1'b1 && !tmo) begin
            err_wait = err_wait | perr[d];
            waits++;
            if (mode == 1 && waits == abort_at) break;
            @(negedge clk);
            guard++;
            if (guard > 20) tmo = 1'b1;
        end
        if (prdy[d] === 1'b1) begin
            rd = prdata[d];
            err_rdy = perr[d];
        end
        if (mode != 0) begin
            psel[d] = 1'b0; pen[d] = 1'b0;
        end
        @(negedge clk);
        rdy_after = prdy[d];
        err_after = perr[d];
        psel[d] = 1'b0; pen[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        psel = '0; pen = '0; pwr = '0; paddr = '0; pwdata = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (prdy[k] !== 1'b0 || prdata[k] !== 8'h00 || perr[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d cyc%0d got rdy=%b rd=%h err=%b exp 0/00/0",
                             k, c, prdy[k], prdata[k], perr[k]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] rd; logic er, ew, ra, ea; int w; bit t;
        xfer(1'b0, 1'b1, 8'h10, 8'hA5, 0, 0, rd, er, w, ew, ra, ea, t);
        model_apply(1'b0, 1'b1, 8'h10, 8'hA5, 0);
        checks++;
        if (t || w != 2 || ra !== 1'b0) begin
            errors++;
            $display("FAIL wr_wait got waits=%0d rdy_after=%b tmo=%0d exp 2/0/0", w, ra, t);
        end
        xfer(1'b0, 1'b0, 8'h10, 8'h00, 0, 0, rd, er, w, ew, ra, ea, t);
        model_apply(1'b0, 1'b0, 8'h10, 8'h00, 0);
        checks++;
        if (t || rd !== 8'hA5 || w != 2 || er !== 1'b0) begin
            errors++;
            $display("FAIL rd_a5 got rd=%h waits=%0d err=%b exp A5/2/0", rd, w, er);
        end
    endtask

    task automatic test_zero_wait();
        logic [7:0] rd; logic er, ew, ra, ea; int w; bit t;
        logic [7:0] ad [4]; logic [7:0] dt [4]; bit wv [4];
        ad = '{8'h00, 8'h01, 8'h00, 8'h01};
        dt = '{8'h11, 8'h22, 8'h11, 8'h22};
        wv = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, wv[i], ad[i], dt[i], 0, 0, rd, er, w, ew, ra, ea, t);
            model_apply(1'b1, wv[i], ad[i], dt[i], 0);
            checks++;
            if (t || w != 0 || ra !== 1'b0) begin
                errors++;
                $display("FAIL zw_ready xfer%0d got waits=%0d rdy_after=%b exp 0/0", i, w, ra);
            end
            if (!wv[i]) begin
                checks++;
                if (rd !== dt[i]) begin
                    errors++;
                    $display("FAIL zw_read xfer%0d got %h exp %h", i, rd, dt[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] rd; logic er, ew, ra, ea; int w; bit t;
        xfer(1'b0, 1'b1, 8'h20, 8'h5A, 1, 1, rd, er, w, ew, ra, ea, t);
        model_apply(1'b0, 1'b1, 8'h20, 8'h5A, 1);
        checks++;
        if (ra !== 1'b0) begin
            errors++;
            $display("FAIL abort_rdy got %b exp 0", ra);
        end
        xfer(1'b0, 1'b0, 8'h20, 8'h00, 0, 0, rd, er, w, ew, ra, ea, t);
        model_apply(1'b0, 1'b0, 8'h20, 8'h00, 0);
        checks++;
        if (t || rd !== 8'h00 || w != 2) begin
            errors++;
            $display("FAIL abort_read got rd=%h waits=%0d exp 00/2", rd, w);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] rd; logic er, ew, ra, ea; int w; bit t;
        xfer(1'b0, 1'b1, 8'hC8, 8'h77, 0, 0, rd, er, w, ew, ra, ea, t);
        model_apply(1'b0, 1'b1, 8'hC8, 8'h77, 0);
        checks++;
        if (t || er !== in_err(8'hC8) || ew !== 1'b0 || ea !== 1'b0 || w != 2) begin
            errors++;
            $display("FAIL oor_wr got err=%b ew=%b ea=%b waits=%0d exp %b/0/0/2",
                     er, ew, ea, w, in_err(8'hC8));
        end
        xfer(1'b0, 1'b0, 8'hC8, 8'h00, 0, 0, rd, er, w, ew, ra, ea, t);
        checks++;
`ifdef APB_SLVERR_EN
        if (t || rd !== 8'h00 || er !== 1'b1 || ew !== 1'b0 || ea !== 1'b0) begin
            errors++;
            $display("FAIL oor_rd got rd=%h err=%b ew=%b ea=%b exp 00/1/0/0", rd, er, ew, ea);
        end
`else
        if (t || rd !== 8'h77 || er !== 1'b0) begin
            errors++;
            $display("FAIL oor_alias_rd got rd=%h err=%b exp 77/0", rd, er);
        end
`endif
        model_apply(1'b0, 1'b0, 8'hC8, 8'h00, 0);
        xfer(1'b0, 1'b0, 8'h00, 8'h00, 0, 0, rd, er, w, ew, ra, ea, t);
        checks++;
        if (t || rd !== model_read(1'b0, 8'h00)) begin
            errors++;
            $display("FAIL oor_mem0 got %h exp %h", rd, model_read(1'b0, 8'h00));
        end
        model_apply(1'b0, 1'b0, 8'h00, 8'h00, 0);
    endtask

    task automatic test_random();
        logic [7:0] rd; logic er, ew, ra, ea; int w; bit t;
        bit d, wr; logic [7:0] a, wd, exp_rd; int mode, ab, sel;
        for (int n = 0; n < 80; n++) begin
            d  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                             : 8'($urandom_range(0, 15));
            wd = 8'($urandom);
            sel = $urandom_range(0, 5);
            mode = (sel < 4) ? 0 : ((sel == 4 && !d) ? 1 : 2);
            ab = $urandom_range(1, 2);
            exp_rd = model_read(d, a);
            xfer(d, wr, a, wd, mode, ab, rd, er, w, ew, ra, ea, t);
            model_apply(d, wr, a, wd, mode);
            checks++;
            if (t || ra !== 1'b0 || ea !== 1'b0 || ew !== 1'b0) begin
                errors++;
                $display("FAIL rnd_hs n%0d dut%0d tmo=%0d rdy_after=%b err_after=%b err_wait=%b exp 0/0/0/0",
                         n, d, t, ra, ea, ew);
            end
            if (mode != 1) begin
                checks++;
                if (w != wait_of(d) || er !== in_err(a)) begin
                    errors++;
                    $display("FAIL rnd_lat n%0d dut%0d a=%h got waits=%0d err=%b exp %0d/%b",
                             n, d, a, w, er, wait_of(d), in_err(a));
                end
                if (!wr) begin
                    checks++;
                    if (rd !== exp_rd) begin
                        errors++;
                        $display("FAIL rnd_rd n%0d dut%0d a=%h got %h exp %h", n, d, a, rd, exp_rd);
                    end
                end
            end
            checks++;
            if (prdata[d] !== last_rd[d]) begin
                errors++;
                $display("FAIL rnd_hold n%0d dut%0d got %h exp %h", n, d, prdata[d], last_rd[d]);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rd; logic er, ew, ra, ea; int w; bit t;
        xfer(1'b0, 1'b1, 8'h10, 8'hA5, 0, 0, rd, er, w, ew, ra, ea, t);
        xfer(1'b0, 1'b0, 8'h10, 8'h00, 0, 0, rd, er, w, ew, ra, ea, t);
        checks++;
        if (rd !== 8'hA5) begin
            errors++;
            $display("FAIL mid_pre_read got %h exp A5", rd);
        end
        psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b0; paddr[0] = 8'h10;
        @(negedge clk);
        pen[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (prdy[0] !== 1'b0 || prdata[0] !== 8'h00 || perr[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got rdy=%b rd=%h err=%b exp 0/00/0", prdy[0], prdata[0], perr[0]);
        end
        @(negedge clk);
        psel = '0; pen = '0;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        xfer(1'b0, 1'b0, 8'h10, 8'h00, 0, 0, rd, er, w, ew, ra, ea, t);
        checks++;
        if (t || rd !== 8'h00 || w != 2) begin
            errors++;
            $display("FAIL mid_after got rd=%h waits=%0d exp 00/2", rd, w);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_abort();
        test_out_of_range();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB completer (slave) at the far end of the APB requester driven by apb_protocol_top. It decodes PSEL/PENABLE/PWRITE, inserts a parameterised number of wait states via PREADY, and services reads and writes into an internal byte-wide register array. It is the memory-mapped target the APB top instantiates for end-to-end transactions.

Parameters:
ADDR_W, 8, PADDR width in bits.
DATA_W, 8, PWDATA/PREAD width in bits.
MEM_DEPTH, 200, number of implemented locations; valid addresses are 0..MEM_DEPTH-1, and MEM_DEPTH must be <= 2**ADDR_W.
WAIT_CYCLES, 2, PREADY-low cycles inserted in every access phase; 0 gives zero-wait transfers.

Ports:
PCLK  input  1  clock, rising edge.
PRESET_n  input  1  asynchronous active-low reset.
PADDR_i  input  ADDR_W  transfer address.
PWDATA_i  input  DATA_W  write data.
PSEL_i  input  1  slave select.
PENABLE_i  input  1  access-phase indicator.
PWRITE_i  input  1  1 = write, 0 = read.
PREADY_o  output  1  transfer-complete handshake (registered).
PREAD_o  output  DATA_W  read data (registered).
PSLVERR_o  output  1  error response (registered; see Optional Feature).

Behaviour:
- Reset (async, PRESET_n=0):
  - State is IDLE.
  - PREADY_o=0, PREAD_o=0, PSLVERR_o=0.
  - Wait counter is cleared.
  - Every memory location is cleared to 0.
- FSM states are IDLE, WAIT and READY.
- IDLE:
  - On PSEL_i=1 and PENABLE_i=0 (setup phase), capture PADDR_i, PWRITE_i and PWDATA_i.
  - Load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else go to READY.
  - PENABLE_i=1 without a prior setup phase is ignored and the FSM stays in IDLE.
- WAIT:
  - PREADY_o=0.
  - While PSEL_i=1 and PENABLE_i=1, decrement the counter each cycle.
  - When the counter reaches 1, go to READY on that edge.
- READY:
  - PREADY_o=1.
  - For a read, PREAD_o is loaded with mem[addr] on the edge that enters READY, so it is valid for the whole PREADY_o=1 cycle.
  - The transfer completes on the edge where PSEL_i, PENABLE_i and PREADY_o are all 1.
  - On completion, a write commits mem[addr]<=wdata, and the FSM returns to IDLE.
  - PREADY_o deasserts in the cycle after completion.
- Latency: PREADY_o rises exactly WAIT_CYCLES cycles after the first access-phase cycle. With WAIT_CYCLES=0, PREADY_o=1 in the first access cycle.
- PREAD_o holds its last value outside read completions. It is not modified by writes.
- Abort: if PSEL_i drops while in WAIT or READY, return to IDLE without writing. PREADY_o=0 next cycle.
- Back-to-back transfers: a setup phase in the cycle after completion is captured normally. There are no dead cycles beyond the APB setup phase.
- Address/data values: the captured address is used and the live PADDR_i is ignored after setup. Writes are full-width; there is no strobe support.
- Reset asserted mid-transfer: immediate return to the reset values above. A pending write is discarded.

Optional Feature:
- Macro: APB_SLVERR_EN.
- Defined:
  - Captured address >= MEM_DEPTH raises PSLVERR_o=1 in the READY cycle only.
  - On such an error, a write is dropped and a read returns PREAD_o=0.
  - Wait-state timing is unchanged.
- Undefined:
  - PSLVERR_o is tied 0.
  - Out-of-range addresses alias to addr % MEM_DEPTH for both read and write.

Decomposition:
- Shared package apb_pkg holds:
  - the typedef enum for IDLE/WAIT/READY;
  - APB_ADDR_W=8 and APB_DATA_W=8 defaults;
  - a localparam helper for counter width, $clog2(WAIT_CYCLES+1) with a minimum of 1.
- One natural sub-module, apb_slave_regfile: the MEM_DEPTH x DATA_W array with async clear, a registered read port and a write enable.
- The FSM, counter and error decode stay in apb_slave_mem.

Test Plan:
- Reset then idle: hold PRESET_n=0 for 2 cycles, release, PSEL_i=0 for 4 cycles -> PREADY_o=0, PREAD_o=0, PSLVERR_o=0 throughout.
- Write then read, WAIT_CYCLES=2: write 0xA5 to addr 0x10, then read addr 0x10 -> PREADY_o low for exactly 2 access cycles then high 1 cycle; read returns PREAD_o=0xA5 with PREADY_o=1.
- Zero-wait (WAIT_CYCLES=0): back-to-back writes 0x11@0x00 and 0x22@0x01, then reads -> PREADY_o=1 in the first access cycle of each transfer; reads return 0x11 and 0x22.
- Abort: write 0x5A@0x20 with PSEL_i dropped during WAIT, then read 0x20 -> PREAD_o=0x00 (write discarded); FSM back in IDLE the cycle after the drop.
- Out of range, with APB_SLVERR_EN: write 0x77@0xC8 (200), read 0xC8 -> PSLVERR_o=1 only in the READY cycle, PREAD_o=0. Without the macro: the read returns 0x77 and mem[0x00]=0x77.
- Reset mid-read: assert PRESET_n=0 during WAIT of a read at 0x10 holding 0xA5 -> outputs go to 0 asynchronously; a subsequent read of 0x10 returns 0x00.
